// File: rtl/qracc_pkg.sv
// Shared types for the QRAcc activation-memory path: grant/return source tags,
// arbiter FSM states and default sizing.
package qracc_pkg;

  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_INT_RD = 2'd1,
    SRC_WQ     = 2'd2,
    SRC_EXT    = 2'd3
  } actmem_src_t;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_DRAIN = 1'b1
  } actmem_state_t;

  localparam int ACTMEM_DATA_W       = 128;
  localparam int ACTMEM_ADDR_W       = 16;
  localparam int ACTMEM_WQ_DEPTH     = 4;
  localparam int ACTMEM_STARVE_LIMIT = 8;

  // A granted access produces a read return when it is a compute read or an
  // external access without write enable.
  function automatic logic src_is_read(actmem_src_t src, logic ext_wen);
    return (src == SRC_INT_RD) || ((src == SRC_EXT) && !ext_wen);
  endfunction

endpackage

// File: rtl/qracc_actmem_wr_queue.sv
// Ofmap writeback FIFO holding {addr, data} pairs in arrival order.
// Push is ignored when full, pop when empty; push+pop in one cycle keeps the count.
module qracc_actmem_wr_queue
  import qracc_pkg::*;
#(
  parameter int DEPTH = ACTMEM_WQ_DEPTH,
  parameter int AW    = ACTMEM_ADDR_W,
  parameter int DW    = ACTMEM_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [AW-1:0]            push_addr_i,
  input  logic [DW-1:0]            push_data_i,
  input  logic                     pop_i,
  output logic [AW-1:0]            head_addr_o,
  output logic [DW-1:0]            head_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [AW+DW-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage has no reset; the count and pointers decide what is valid,
  // so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= {push_addr_i, push_data_i};
  end

  assign {head_addr_o, head_data_o} = mem_q[rd_ptr_q];

endmodule

// File: rtl/qracc_actmem_arbiter.sv
// Single-port arbiter for the activation SRAM: compute reads, queued ofmap writes
// and the external bus. Optional starvation guard: QRACC_ACTMEM_STARVE_GUARD_EN.
module qracc_actmem_arbiter
  import qracc_pkg::*;
#(
  parameter int dataWidth   = ACTMEM_DATA_W,
  parameter int addrBits    = ACTMEM_ADDR_W,
  parameter int wqDepth     = ACTMEM_WQ_DEPTH,
  parameter int starveLimit = ACTMEM_STARVE_LIMIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 int_rd_req,
  input  logic [addrBits-1:0]  int_rd_addr,
  output logic                 int_rd_gnt,
  output logic [dataWidth-1:0] int_rd_data,
  output logic                 int_rd_data_valid,
  input  logic                 int_wr_valid,
  input  logic [addrBits-1:0]  int_wr_addr,
  input  logic [dataWidth-1:0] int_wr_data,
  output logic                 int_wr_ready,
  input  logic                 ext_req,
  input  logic                 ext_wen,
  input  logic [addrBits-1:0]  ext_addr,
  input  logic [dataWidth-1:0] ext_wdata,
  output logic                 ext_gnt,
  output logic [dataWidth-1:0] ext_rdata,
  output logic                 ext_rdata_valid,
  input  logic                 flush,
  output logic                 flush_done,
  output logic                 wq_empty,
  output logic                 mem_cen,
  output logic                 mem_wen,
  output logic [addrBits-1:0]  mem_addr,
  output logic [dataWidth-1:0] mem_wdata,
  input  logic [dataWidth-1:0] mem_rdata
);

  localparam int CW = $clog2(wqDepth) + 1;

  if (wqDepth < 2 || (wqDepth & (wqDepth - 1)) != 0) begin : g_bad_depth
    $error("qracc_actmem_arbiter: wqDepth must be a power of two >= 2");
  end
  if (starveLimit < 1) begin : g_bad_limit
    $error("qracc_actmem_arbiter: starveLimit must be >= 1");
  end

  actmem_state_t           state_q;
  actmem_src_t             gnt_src;
  actmem_src_t             rd_src_q;
  logic                    wq_full, wq_is_empty, wq_push, wq_pop;
  logic [CW-1:0]           wq_count;
  logic [addrBits-1:0]     wq_head_addr;
  logic [dataWidth-1:0]    wq_head_data;
  logic                    drain_done;

  assign int_wr_ready = (wq_count != CW'(wqDepth));
  assign wq_push      = int_wr_valid && int_wr_ready;
  assign wq_pop       = (gnt_src == SRC_WQ);

  qracc_actmem_wr_queue #(
    .DEPTH (wqDepth),
    .AW    (addrBits),
    .DW    (dataWidth)
  ) u_wr_queue (
    .clk         (clk),
    .rst         (rst),
    .push_i      (wq_push),
    .push_addr_i (int_wr_addr),
    .push_data_i (int_wr_data),
    .pop_i       (wq_pop),
    .head_addr_o (wq_head_addr),
    .head_data_o (wq_head_data),
    .full_o      (wq_full),
    .empty_o     (wq_is_empty),
    .count_o     (wq_count)
  );

`ifdef QRACC_ACTMEM_STARVE_GUARD_EN
  localparam int SW = $clog2(starveLimit + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(starveLimit);

  logic [SW-1:0] wq_starve_q, wq_starve_d, ext_starve_q, ext_starve_d;
  logic          wq_starved, ext_starved;

  assign wq_starved  = (wq_starve_q == STARVE_MAX) && !wq_is_empty;
  assign ext_starved = (ext_starve_q == STARVE_MAX) && ext_req;

  // Count consecutive pass-overs of a pending requester, saturating at the limit.
  always_comb begin
    wq_starve_d  = '0;
    ext_starve_d = '0;
    if (!wq_is_empty && gnt_src != SRC_WQ)
      wq_starve_d = (wq_starve_q == STARVE_MAX) ? STARVE_MAX : wq_starve_q + 1'b1;
    if (ext_req && gnt_src != SRC_EXT)
      ext_starve_d = (ext_starve_q == STARVE_MAX) ? STARVE_MAX : ext_starve_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wq_starve_q  <= '0;
      ext_starve_q <= '0;
    end else begin
      wq_starve_q  <= wq_starve_d;
      ext_starve_q <= ext_starve_d;
    end
  end
`endif

  // NOTE: gnt_src is defaulted before any branch so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    gnt_src = SRC_NONE;
    if (!rst) begin
      if (state_q == S_DRAIN) begin
        if (!wq_is_empty)  gnt_src = SRC_WQ;
        else if (ext_req)  gnt_src = SRC_EXT;
      end else if (wq_full) begin
        gnt_src = SRC_WQ;
`ifdef QRACC_ACTMEM_STARVE_GUARD_EN
      end else if (wq_starved) begin
        gnt_src = SRC_WQ;
      end else if (ext_starved) begin
        gnt_src = SRC_EXT;
`endif
      end else if (int_rd_req) begin
        gnt_src = SRC_INT_RD;
      end else if (!wq_is_empty) begin
        gnt_src = SRC_WQ;
      end else if (ext_req) begin
        gnt_src = SRC_EXT;
      end
    end
  end

  assign int_rd_gnt = (gnt_src == SRC_INT_RD);
  assign ext_gnt    = (gnt_src == SRC_EXT);

  always_comb begin
    mem_cen   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (gnt_src)
      SRC_INT_RD: begin
        mem_cen  = 1'b1;
        mem_addr = int_rd_addr;
      end
      SRC_WQ: begin
        mem_cen   = 1'b1;
        mem_wen   = 1'b1;
        mem_addr  = wq_head_addr;
        mem_wdata = wq_head_data;
      end
      SRC_EXT: begin
        mem_cen   = 1'b1;
        mem_wen   = ext_wen;
        mem_addr  = ext_addr;
        mem_wdata = ext_wen ? ext_wdata : '0;
      end
      default: ;
    endcase
  end

  // Tag the cycle's read so the SRAM return one cycle later reaches its owner.
  always_ff @(posedge clk) begin
    if (rst) rd_src_q <= SRC_NONE;
    else     rd_src_q <= src_is_read(gnt_src, ext_wen) ? gnt_src : SRC_NONE;
  end

  assign int_rd_data_valid = !rst && (rd_src_q == SRC_INT_RD);
  assign ext_rdata_valid   = !rst && (rd_src_q == SRC_EXT);
  assign int_rd_data       = int_rd_data_valid ? mem_rdata : '0;
  assign ext_rdata         = ext_rdata_valid ? mem_rdata : '0;

  assign drain_done = (state_q == S_DRAIN) && wq_is_empty && (gnt_src != SRC_WQ);
  assign flush_done = !rst && drain_done;
  assign wq_empty   = rst || wq_is_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
    end else begin
      unique case (state_q)
        S_RUN:   if (flush)      state_q <= S_DRAIN;
        S_DRAIN: if (drain_done) state_q <= S_RUN;
        default:                 state_q <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_qracc_actmem_arbiter.sv
// Self-checking bench for qracc_actmem_arbiter: directed scenarios followed by
// random traffic, all checked against a queue-based reference model each cycle.
module tb_qracc_actmem_arbiter;
  import qracc_pkg::*;

  localparam int DW    = 128;
  localparam int AW    = 16;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
`ifdef QRACC_ACTMEM_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          int_rd_req;
  logic [AW-1:0] int_rd_addr;
  logic          int_rd_gnt;
  logic [DW-1:0] int_rd_data;
  logic          int_rd_data_valid;
  logic          int_wr_valid;
  logic [AW-1:0] int_wr_addr;
  logic [DW-1:0] int_wr_data;
  logic          int_wr_ready;
  logic          ext_req, ext_wen;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_gnt;
  logic [DW-1:0] ext_rdata;
  logic          ext_rdata_valid;
  logic          flush, flush_done, wq_empty;
  logic          mem_cen, mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  qracc_actmem_arbiter dut (
    .clk               (clk),
    .rst               (rst),
    .int_rd_req        (int_rd_req),
    .int_rd_addr       (int_rd_addr),
    .int_rd_gnt        (int_rd_gnt),
    .int_rd_data       (int_rd_data),
    .int_rd_data_valid (int_rd_data_valid),
    .int_wr_valid      (int_wr_valid),
    .int_wr_addr       (int_wr_addr),
    .int_wr_data       (int_wr_data),
    .int_wr_ready      (int_wr_ready),
    .ext_req           (ext_req),
    .ext_wen           (ext_wen),
    .ext_addr          (ext_addr),
    .ext_wdata         (ext_wdata),
    .ext_gnt           (ext_gnt),
    .ext_rdata         (ext_rdata),
    .ext_rdata_valid   (ext_rdata_valid),
    .flush             (flush),
    .flush_done        (flush_done),
    .wq_empty          (wq_empty),
    .mem_cen           (mem_cen),
    .mem_wen           (mem_wen),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_rdata         (mem_rdata)
  );

  // SRAM macro model: one read/write port, one-cycle read latency.
  logic [DW-1:0] sram [0:65535];
  logic [DW-1:0] sram_rdata_q = '0;
  assign mem_rdata = sram_rdata_q;
  always @(posedge clk) begin
    if (mem_cen) begin
      if (mem_wen) sram[mem_addr] <= mem_wdata;
      else         sram_rdata_q   <= sram[mem_addr];
    end
  end

  // Reference model: queue of pending writes, expected memory image, drain flag,
  // starvation counts and the read return expected next cycle.
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           model_q[$];
  logic [DW-1:0] ref_mem [0:65535];
  bit            m_drain;
  int            m_wq_starve, m_ext_starve;
  actmem_src_t   m_pend;
  logic [DW-1:0] m_pend_data;
  int            checks, fails;

  function automatic logic [DW-1:0] init_word(int a);
    return {32'(a) ^ 32'hC0DE_0000, ~32'(a), 32'(a) * 32'd7, 32'h5A5A_5A5A};
  endfunction

  function automatic logic [DW-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic actmem_src_t model_grant();
    int n = model_q.size();
    if (rst) return SRC_NONE;
    if (m_drain) return (n > 0) ? SRC_WQ : (ext_req ? SRC_EXT : SRC_NONE);
    if (n == DEPTH) return SRC_WQ;
    if (GUARD && n > 0 && m_wq_starve == LIMIT) return SRC_WQ;
    if (GUARD && ext_req && m_ext_starve == LIMIT) return SRC_EXT;
    if (int_rd_req) return SRC_INT_RD;
    if (n > 0) return SRC_WQ;
    if (ext_req) return SRC_EXT;
    return SRC_NONE;
  endfunction

  task automatic auto_check(input actmem_src_t g);
    int            n = model_q.size();
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          ew;
    ea = '0; ed = '0; ew = 1'b0;
    case (g)
      SRC_INT_RD: ea = int_rd_addr;
      SRC_WQ:     begin ea = model_q[0].addr; ed = model_q[0].data; ew = 1'b1; end
      SRC_EXT:    begin ea = ext_addr; ew = ext_wen; ed = ext_wen ? ext_wdata : '0; end
      default: ;
    endcase
    check("int_rd_gnt", int_rd_gnt, g == SRC_INT_RD);
    check("ext_gnt", ext_gnt, g == SRC_EXT);
    check("mem_cen", mem_cen, g != SRC_NONE);
    check("mem_wen", mem_wen, ew);
    check("mem_addr", mem_addr, ea);
    check("mem_wdata", mem_wdata, ed);
    if (!rst) check("int_wr_ready", int_wr_ready, n != DEPTH);
    check("wq_empty", wq_empty, rst || n == 0);
    check("flush_done", flush_done, !rst && m_drain && n == 0);
    check("int_rd_valid", int_rd_data_valid, !rst && m_pend == SRC_INT_RD);
    check("int_rd_data", int_rd_data, (!rst && m_pend == SRC_INT_RD) ? m_pend_data : '0);
    check("ext_rd_valid", ext_rdata_valid, !rst && m_pend == SRC_EXT);
    check("ext_rdata", ext_rdata, (!rst && m_pend == SRC_EXT) ? m_pend_data : '0);
  endtask

  task automatic model_update(input actmem_src_t g);
    int n = model_q.size();
    if (rst) begin
      model_q.delete();
      m_drain = 1'b0; m_wq_starve = 0; m_ext_starve = 0; m_pend = SRC_NONE;
      return;
    end
    m_pend = SRC_NONE;
    m_pend_data = '0;
    case (g)
      SRC_INT_RD: begin m_pend = SRC_INT_RD; m_pend_data = ref_mem[int_rd_addr]; end
      SRC_WQ: begin
        ref_mem[model_q[0].addr] = model_q[0].data;
        void'(model_q.pop_front());
      end
      SRC_EXT: begin
        if (ext_wen) ref_mem[ext_addr] = ext_wdata;
        else begin m_pend = SRC_EXT; m_pend_data = ref_mem[ext_addr]; end
      end
      default: ;
    endcase
    if (int_wr_valid && n != DEPTH) model_q.push_back({int_wr_addr, int_wr_data});
    m_wq_starve  = (n > 0 && g != SRC_WQ) ? ((m_wq_starve < LIMIT) ? m_wq_starve + 1 : LIMIT) : 0;
    m_ext_starve = (ext_req && g != SRC_EXT) ? ((m_ext_starve < LIMIT) ? m_ext_starve + 1 : LIMIT) : 0;
    if (!m_drain) m_drain = flush;
    else if (n == 0) m_drain = 1'b0;
  endtask

  // One clock cycle: settle, check against the model, advance the model, move on.
  task automatic step();
    actmem_src_t g;
    #1;
    g = model_grant();
    auto_check(g);
    model_update(g);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 1'b0; int_rd_req = 1'b0; int_rd_addr = '0; int_wr_valid = 1'b0;
    int_wr_addr = '0; int_wr_data = '0; ext_req = 1'b0; ext_wen = 1'b0;
    ext_addr = '0; ext_wdata = '0; flush = 1'b0;
  endtask

  initial begin
    int            cnt, first;
    logic [DW-1:0] ext_word;
    checks = 0; fails = 0;
    m_drain = 1'b0; m_wq_starve = 0; m_ext_starve = 0; m_pend = SRC_NONE; m_pend_data = '0;
    for (int i = 0; i < 65536; i++) begin
      sram[i]    = init_word(i);
      ref_mem[i] = init_word(i);
    end
    sram[5]    = 128'hA5;
    ref_mem[5] = 128'hA5;
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);

    // Reset held two cycles with every request asserted.
    rst = 1'b1; int_rd_req = 1'b1; ext_req = 1'b1; int_wr_valid = 1'b1; flush = 1'b1;
    int_wr_addr = 16'd3; ext_addr = 16'd4;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("rst_int_rd_gnt", int_rd_gnt, 1'b0);
      check("rst_ext_gnt", ext_gnt, 1'b0);
      step();
    end
    idle_inputs();
    #1;
    check("post_rst_wq_empty", wq_empty, 1'b1);
    check("post_rst_wr_ready", int_wr_ready, 1'b1);
    step();

    // Compute read of address 5 returns 0xA5 one cycle after the grant.
    int_rd_req = 1'b1; int_rd_addr = 16'd5;
    #1 check("lat_gnt", int_rd_gnt, 1'b1);
    step();
    int_rd_req = 1'b0;
    #1;
    check("lat_valid", int_rd_data_valid, 1'b1);
    check("lat_data", int_rd_data, 128'hA5);
    step();

    // External write then read back of the same word.
    ext_word = rand_word();
    ext_req = 1'b1; ext_wen = 1'b1; ext_addr = 16'd9; ext_wdata = ext_word;
    step();
    ext_wen = 1'b0; ext_wdata = '0;
    #1 check("ext_rd_gnt", ext_gnt, 1'b1);
    step();
    ext_req = 1'b0;
    #1;
    check("ext_rd_valid_dir", ext_rdata_valid, 1'b1);
    check("ext_rd_data_dir", ext_rdata, ext_word);
    step();

    // Fill the queue under continuous compute reads; full forces a WQ grant.
    int_rd_req = 1'b1; int_rd_addr = 16'd2;
    for (int k = 0; k < DEPTH; k++) begin
      int_wr_valid = 1'b1; int_wr_addr = AW'(16 + k); int_wr_data = rand_word();
      step();
    end
    int_wr_valid = 1'b0;
    #1;
    check("full_wr_ready", int_wr_ready, 1'b0);
    check("full_rd_gnt", int_rd_gnt, 1'b0);
    check("full_wq_write", mem_wen, 1'b1);
    check("full_wq_addr", mem_addr, 16'd16);
    step();

    // Flush with three entries queued: drain writes back to back, then flush_done.
    flush = 1'b1;
    #1 check("flush_cycle_rd_gnt", int_rd_gnt, 1'b1);
    step();
    flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("drain_no_rd_gnt", int_rd_gnt, 1'b0);
      check("drain_wen", mem_wen, 1'b1);
      check("drain_addr", mem_addr, AW'(17 + k));
      step();
    end
    #1;
    check("drain_flush_done", flush_done, 1'b1);
    check("drain_wq_empty", wq_empty, 1'b1);
    check("drain_done_rd_gnt", int_rd_gnt, 1'b0);
    step();
    #1 check("after_drain_rd_gnt", int_rd_gnt, 1'b1);
    step();

    // External reads competing with continuous compute reads.
    ext_req = 1'b1; ext_wen = 1'b0; ext_addr = 16'd7;
    cnt = 0; first = -1;
    for (int k = 0; k < LIMIT + 2; k++) begin
      #1;
      if (ext_gnt) begin
        cnt++;
        if (first < 0) first = k;
      end
      step();
    end
    check("starve_ext_count", cnt, GUARD ? 1 : 0);
    check("starve_ext_cycle", first, GUARD ? LIMIT : -1);
    ext_req = 1'b0; int_rd_req = 1'b0;
    step();

    // Push and pop together with two entries queued keeps FIFO order.
    int_rd_req = 1'b1;
    for (int k = 0; k < 2; k++) begin
      int_wr_valid = 1'b1; int_wr_addr = AW'(32 + k); int_wr_data = rand_word();
      step();
    end
    int_rd_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      int_wr_valid = 1'b1; int_wr_addr = AW'(34 + k); int_wr_data = rand_word();
      #1;
      check("pp_addr", mem_addr, AW'(32 + k));
      check("pp_wen", mem_wen, 1'b1);
      check("pp_ready", int_wr_ready, 1'b1);
      check("pp_nonempty", wq_empty, 1'b0);
      step();
    end
    int_wr_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1 check("pp_tail_addr", mem_addr, AW'(35 + k));
      step();
    end
    #1 check("pp_final_empty", wq_empty, 1'b1);
    step();

    // Random traffic over a small address window to exercise read-after-write.
    for (int c = 0; c < 800; c++) begin
      rst          = ($urandom_range(0, 63) == 0);
      int_rd_req   = ($urandom_range(0, 2) != 0);
      int_rd_addr  = AW'($urandom_range(0, 15));
      int_wr_valid = ($urandom_range(0, 1) == 1);
      int_wr_addr  = AW'($urandom_range(0, 15));
      int_wr_data  = rand_word();
      ext_req      = ($urandom_range(0, 1) == 1);
      ext_wen      = ($urandom_range(0, 1) == 1);
      ext_addr     = AW'($urandom_range(0, 15));
      ext_wdata    = rand_word();
      flush        = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
